// File: rtl/key_menu_pkg.sv
// Shared types and constants for the three-button menu controller.
// Imported by the key front end and the menu FSM.
package key_menu_pkg;

    typedef enum logic {
        BROWSE = 1'b0,
        EDIT   = 1'b1
    } menu_state_t;

    localparam int KEY_UP   = 0;
    localparam int KEY_DOWN = 1;
    localparam int KEY_OK   = 2;
    localparam int N_KEYS   = 3;

    // Counter width able to hold the value n itself.
    function automatic int cnt_width(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/key_evt_gen.sv
// One push-button front end: synchroniser, debounce, press pulse
// and optional long-press auto-repeat, producing single-cycle events.
module key_evt_gen
    import key_menu_pkg::*;
#(
    parameter int DEB_CYCLES    = 500000,
    parameter int LONG_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000,
    parameter bit REPEAT_EN     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic evt
);

    localparam int DEB_W  = cnt_width(DEB_CYCLES);
    localparam int LONG_W = cnt_width(LONG_CYCLES);
    localparam int REP_W  = cnt_width(REPEAT_CYCLES);

    logic              sync_a;
    logic              sync_b;
    logic              deb_level;
    logic              deb_prev;
    logic [DEB_W-1:0]  deb_cnt;
    logic [LONG_W-1:0] hold_cnt;
    logic [REP_W-1:0]  rep_cnt;
    logic              press_edge;
    logic              hold_done;
    logic              rep_fire;

    // Two-flop synchroniser; idles released (high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
        end else begin
            sync_a <= key_n;
            sync_b <= sync_a;
        end
    end

    // Accept a new level only after DEB_CYCLES consecutive disagreements.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_level <= 1'b1;
            deb_cnt   <= '0;
        end else if (sync_b == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_cnt == DEB_W'(DEB_CYCLES - 1)) begin
            deb_level <= sync_b;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + DEB_W'(1);
        end
    end

    assign press_edge = deb_prev & ~deb_level;
    assign hold_done  = (hold_cnt == LONG_W'(LONG_CYCLES));
    assign rep_fire   = REPEAT_EN && !deb_level &&
                        hold_done && (rep_cnt == '0);

    // Hold timer saturates at LONG_CYCLES, then the repeat phase free-runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            rep_cnt  <= '0;
        end else if (deb_level) begin
            hold_cnt <= '0;
            rep_cnt  <= '0;
        end else if (!hold_done) begin
            hold_cnt <= hold_cnt + LONG_W'(1);
        end else if (rep_cnt == REP_W'(REPEAT_CYCLES - 1)) begin
            rep_cnt <= '0;
        end else begin
            rep_cnt <= rep_cnt + REP_W'(1);
        end
    end

    // Registered event: press edge or auto-repeat tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_prev <= 1'b1;
            evt      <= 1'b0;
        end else begin
            deb_prev <= deb_level;
            evt      <= press_edge | rep_fire;
        end
    end

endmodule

// File: rtl/key_menu_ctl.sv
// Three-button BROWSE/EDIT menu: selects an item, edits a shadow
// copy and commits it atomically into the value bank.
module key_menu_ctl
    import key_menu_pkg::*;
#(
    parameter int N_ITEMS        = 4,
    parameter int VAL_WIDTH      = 4,
    parameter int VAL_MAX        = 15,
    parameter int VAL_INIT       = 0,
    parameter int DEB_CYCLES     = 500000,
    parameter int LONG_CYCLES    = 25000000,
    parameter int REPEAT_CYCLES  = 5000000,
    parameter int TIMEOUT_CYCLES = 250000000,
    parameter int SEL_W = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         key_up,
    input  logic                         key_down,
    input  logic                         key_ok,
    output logic [SEL_W-1:0]             sel_idx,
    output logic                         edit_mode,
    output logic [VAL_WIDTH-1:0]         edit_val,
    output logic [N_ITEMS*VAL_WIDTH-1:0] val_bus,
    output logic                         cfg_update
);

    localparam int IDLE_W = cnt_width(TIMEOUT_CYCLES);
    localparam logic [VAL_WIDTH:0] MAX_EXT =
        (VAL_WIDTH + 1)'(VAL_MAX);
    localparam logic [VAL_WIDTH-1:0] INIT_V =
        VAL_WIDTH'(VAL_INIT);
    localparam logic [SEL_W-1:0] SEL_LAST =
        SEL_W'(N_ITEMS - 1);

    logic [N_KEYS-1:0]    key_raw;
    logic [N_KEYS-1:0]    evt;
    logic                 ok_ev;
    logic                 up_ev;
    logic                 dn_ev;
    logic                 any_ev;
    menu_state_t          state;
    logic [IDLE_W-1:0]    idle_cnt;
    logic [SEL_W-1:0]     sel_inc;
    logic [SEL_W-1:0]     sel_dec;
    logic [VAL_WIDTH-1:0] cur_val;
    logic [VAL_WIDTH-1:0] inc_item;
    logic [VAL_WIDTH-1:0] dec_item;
    logic [VAL_WIDTH:0]   val_inc;
    logic [VAL_WIDTH:0]   val_dec;
    logic [VAL_WIDTH-1:0] inc_sat;
    logic [VAL_WIDTH-1:0] dec_sat;

    assign key_raw[KEY_UP]   = key_up;
    assign key_raw[KEY_DOWN] = key_down;
    assign key_raw[KEY_OK]   = key_ok;

    for (genvar k = 0; k < N_KEYS; k++) begin : g_key
        key_evt_gen #(
            .DEB_CYCLES   (DEB_CYCLES),
            .LONG_CYCLES  (LONG_CYCLES),
            .REPEAT_CYCLES(REPEAT_CYCLES),
            .REPEAT_EN    (k != KEY_OK)
        ) u_evt (
            .clk  (clk),
            .rst  (rst),
            .key_n(key_raw[k]),
            .evt  (evt[k])
        );
    end

    // OK wins; simultaneous UP and DOWN cancel each other.
    always_comb begin
        ok_ev  = evt[KEY_OK];
        up_ev  = evt[KEY_UP] & ~evt[KEY_DOWN] & ~evt[KEY_OK];
        dn_ev  = evt[KEY_DOWN] & ~evt[KEY_UP] & ~evt[KEY_OK];
        any_ev = |evt;
    end

    // Wrapping neighbours of the selection and their committed values.
    always_comb begin
        sel_inc  = (sel_idx == SEL_LAST) ? '0 : sel_idx + SEL_W'(1);
        sel_dec  = (sel_idx == '0) ? SEL_LAST : sel_idx - SEL_W'(1);
        cur_val  = val_bus[int'(sel_idx)*VAL_WIDTH +: VAL_WIDTH];
        inc_item = val_bus[int'(sel_inc)*VAL_WIDTH +: VAL_WIDTH];
        dec_item = val_bus[int'(sel_dec)*VAL_WIDTH +: VAL_WIDTH];
    end

    // Saturating shadow arithmetic with one guard bit.
    always_comb begin
        val_inc = {1'b0, edit_val} + (VAL_WIDTH + 1)'(1);
        val_dec = {1'b0, edit_val} - (VAL_WIDTH + 1)'(1);
        inc_sat = (val_inc > MAX_EXT) ? MAX_EXT[VAL_WIDTH-1:0]
                                      : val_inc[VAL_WIDTH-1:0];
        dec_sat = val_dec[VAL_WIDTH] ? '0 : val_dec[VAL_WIDTH-1:0];
    end

    // Menu FSM with shadow register, value bank and commit strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= BROWSE;
            sel_idx    <= '0;
            edit_mode  <= 1'b0;
            edit_val   <= INIT_V;
            val_bus    <= {N_ITEMS{INIT_V}};
            cfg_update <= 1'b0;
            idle_cnt   <= '0;
        end else begin
            cfg_update <= 1'b0;
            unique case (state)
                BROWSE: begin
                    idle_cnt <= '0;
                    unique case (1'b1)
                        ok_ev: begin
                            edit_val  <= cur_val;
                            edit_mode <= 1'b1;
                            state     <= EDIT;
                        end
                        up_ev: begin
                            sel_idx  <= sel_inc;
                            edit_val <= inc_item;
                        end
                        dn_ev: begin
                            sel_idx  <= sel_dec;
                            edit_val <= dec_item;
                        end
                        default: ;
                    endcase
                end
                EDIT: begin
                    unique case (1'b1)
                        ok_ev: begin
                            val_bus[int'(sel_idx)*VAL_WIDTH +: VAL_WIDTH]
                                       <= edit_val;
                            cfg_update <= 1'b1;
                            edit_mode  <= 1'b0;
                            idle_cnt   <= '0;
                            state      <= BROWSE;
                        end
                        up_ev: begin
                            edit_val <= inc_sat;
                            idle_cnt <= '0;
                        end
                        dn_ev: begin
                            edit_val <= dec_sat;
                            idle_cnt <= '0;
                        end
                        default: begin
                            if (any_ev) begin
                                idle_cnt <= '0;
                            end else if (idle_cnt ==
                                         IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                                edit_val  <= cur_val;
                                edit_mode <= 1'b0;
                                idle_cnt  <= '0;
                                state     <= BROWSE;
                            end else begin
                                idle_cnt <= idle_cnt + IDLE_W'(1);
                            end
                        end
                    endcase
                end
                default: state <= BROWSE;
            endcase
        end
    end

endmodule

// File: doc/key_menu_ctl.md
Name: key_menu_ctl

Overview:
- Three-button menu controller (UP, DOWN, OK) that turns raw push-buttons into a bank of N_ITEMS configuration values for the video/processing datapath, e.g. mode select, brightness level, overlay enable.
- Each raw key is synchronised and debounced, with press-edge detection and long-press auto-repeat.
- A BROWSE/EDIT state machine selects an item, edits a shadow copy, then commits it atomically with a one-cycle update strobe.

Parameters:
- N_ITEMS, 4: number of configurable items; sel_idx width is $clog2(N_ITEMS), minimum 1 bit.
- VAL_WIDTH, 4: width of each item value.
- VAL_MAX, 15: maximum value of every item, with VAL_MAX < 2**VAL_WIDTH.
- VAL_INIT, 0: reset value of every item.
- DEB_CYCLES, 500000: consecutive stable cycles required to accept a key level change.
- LONG_CYCLES, 25000000: hold time after the press event before auto-repeat starts.
- REPEAT_CYCLES, 5000000: period between auto-repeat events.
- TIMEOUT_CYCLES, 250000000: idle cycles in EDIT before the edit is abandoned.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: asynchronous, active-high reset.
- key_up, input, 1: raw button, active-low, asynchronous.
- key_down, input, 1: raw button, active-low, asynchronous.
- key_ok, input, 1: raw button, active-low, asynchronous.
- sel_idx, output, $clog2(N_ITEMS): currently selected item.
- edit_mode, output, 1: 1 while the FSM is in EDIT.
- edit_val, output, VAL_WIDTH: shadow value under edit; equals the committed value of sel_idx while in BROWSE.
- val_bus, output, N_ITEMS*VAL_WIDTH: committed values; item i occupies bits [i*VAL_WIDTH +: VAL_WIDTH].
- cfg_update, output, 1: one-cycle pulse on the cycle val_bus changes.

Behaviour:
- Reset (asynchronous, active-high):
  - state=BROWSE, sel_idx=0, edit_mode=0, cfg_update=0.
  - Every val_bus item = VAL_INIT; edit_val = VAL_INIT.
  - Debounced levels = 1 (released), all counters = 0.
  - Reset asserted mid-edit discards the shadow; nothing is committed.
- Per-key front end:
  - Two-flop synchroniser; sync flops reset to 1.
  - deb_level flips on the DEB_CYCLES-th consecutive clock edge at which the synced level differs from deb_level.
  - The stable counter clears on any cycle where the synced level equals deb_level.
- Press event:
  - Registered single-cycle pulse, one cycle after deb_level falls 1->0.
  - Release (0->1) produces no event.
- Auto-repeat (UP and DOWN only; OK never repeats):
  - While deb_level stays 0, an extra event fires LONG_CYCLES after the press event.
  - Further events fire every REPEAT_CYCLES after that.
  - Hold counters clear on release; they saturate and do not wrap.
- Event arbitration, per cycle:
  - OK has priority.
  - UP and DOWN in the same cycle without OK: both ignored.
  - Events not consumed are dropped, never queued.
- BROWSE state:
  - UP: sel_idx+1, wrapping N_ITEMS-1 -> 0.
  - DOWN: sel_idx-1, wrapping 0 -> N_ITEMS-1.
  - OK: load edit_val from item sel_idx, go to EDIT, edit_mode=1.
- EDIT state:
  - UP: edit_val+1, saturating at VAL_MAX.
  - DOWN: edit_val-1, saturating at 0.
  - OK: write edit_val into item sel_idx, pulse cfg_update for exactly 1 cycle, return to BROWSE.
  - A commit with an unchanged value still pulses cfg_update.
  - Idle counter clears on any UP/DOWN/OK event. When it reaches TIMEOUT_CYCLES, return to BROWSE with no write and no pulse, and edit_val reloads the committed value.
  - sel_idx is frozen while in EDIT.
- Latency:
  - All outputs are registered.
  - FSM outputs change on the clock edge after the press pulse.
  - Raw edge to output change = 2 (sync) + DEB_CYCLES + 1 (pulse) + 1 (FSM) cycles, exact.
- Widths:
  - Counters are sized with $clog2 of their parameter + 1.
  - Value arithmetic uses VAL_WIDTH+1 bits internally before saturation.

Decomposition:
- Package key_menu_pkg:
  - FSM state enum {BROWSE, EDIT}.
  - Key index constants KEY_UP=0, KEY_DOWN=1, KEY_OK=2.
- Sub-module key_evt_gen:
  - Handles one key: synchroniser, debounce, press pulse, optional auto-repeat enabled by parameter REPEAT_EN.
  - Instantiated three times, with REPEAT_EN=0 for OK.
- Top level holds the arbiter, FSM, shadow register and value bank.

Test Plan (bench overrides DEB_CYCLES=4, LONG_CYCLES=20, REPEAT_CYCLES=5, TIMEOUT_CYCLES=100, N_ITEMS=4, VAL_MAX=15):
- Bounce rejection: key_up toggles every 2 cycles for 20 cycles, then stays low -> exactly one event. sel_idx 0->1 exactly 8 cycles after the final falling edge.
- Wrap: from reset, 1 DOWN press -> sel_idx=3. Then 1 UP press -> sel_idx=0. val_bus unchanged, cfg_update never asserted.
- Edit and commit: OK, 3 UP presses, OK -> edit_mode 1->0, val_bus item0 = 3, cfg_update high for exactly 1 cycle. Other items remain 0.
- Saturation and repeat: edit item 2, hold UP for 200 cycles -> edit_val climbs via repeat and stops at 15. Hold DOWN for 200 cycles -> stops at 0. Commit -> item2 = 0 with cfg_update pulse.
- Timeout and priority: enter EDIT, 2 UP presses, idle 100 cycles -> edit_mode=0, no cfg_update, edit_val equals committed value. Assert UP and DOWN together -> no change. Assert OK and UP together -> OK taken.
- Async reset mid-edit: assert rst while edit_mode=1 and edit_val=7 -> outputs return to reset values immediately without waiting for a clock edge, and no cfg_update pulse.
